fsk_spi_config: RTL

Write-only SPI configuration slave for the FSK modem. Samples the `cs_n`, `sck` and `mosi` pins in the `clk` domain and decodes 16-bit frames. Keeps the modem's tone, baud and control registers, which the modulator NCO, the demodulator and the data path read directly. It sits between the chip input pins and the modem core.

---
 rtl/fsk_spi_config.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/fsk_spi_config.sv
// ============================================================================
// fsk_spi_config
//
// Write-only SPI configuration slave for the FSK modem. The three SPI pins are
// asynchronous to clk; they are brought into the clk domain through two
// synchroniser flops and a third history flop that is used for edge detection.
// 16-bit frames (MSB first, SPI mode 0) are shifted in while cs_n is low and
// decoded when cs_n rises:
//   frame[15:12] = register address, frame[11:0] = data.
//
// Ports
//   clk         in   system clock, all logic on its rising edge
//   rst         in   synchronous active-high reset
//   cs_n        in   SPI chip select (asynchronous pin, active low)
//   sck         in   SPI clock (asynchronous pin, data sampled on rising edge)
//   mosi        in   SPI data (asynchronous pin, MSB first)
//   mark_inc    out  [11:0] NCO phase increment for bit 1
//   space_inc   out  [11:0] NCO phase increment for bit 0
//   baud_div    out  [11:0] clk cycles per symbol minus one
//   ctrl        out  [3:0]  {rx_invert, tx_invert, loopback, tx_enable}
//   cfg_update  out  one-cycle pulse when a register write (or soft reset)
//                    is committed
//   frame_err   out  one-cycle pulse when a frame is rejected
// ============================================================================
module fsk_spi_config #(
    parameter logic [11:0] MARK_RST  = 12'h0C8,
    parameter logic [11:0] SPACE_RST = 12'h0F0,
    parameter logic [11:0] BAUD_RST  = 12'h1A0,
    parameter logic [3:0]  CTRL_RST  = 4'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        sck,
    input  logic        mosi,
    output logic [11:0] mark_inc,
    output logic [11:0] space_inc,
    output logic [11:0] baud_div,
    output logic [3:0]  ctrl,
    output logic        cfg_update,
    output logic        frame_err
);

    // ------------------------------------------------------------------
    // Pin synchronisers. Bit order in the pin vectors: {mosi, sck, cs_n}.
    // cs_n idles high, so its chain resets to 1; that way a reset never
    // fabricates a chip-select edge on its own.
    // ------------------------------------------------------------------
    localparam int          NPIN    = 3;
    localparam logic [2:0]  PIN_RST = 3'b001;
    localparam int          PIN_CS  = 0;
    localparam int          PIN_SCK = 1;
    localparam int          PIN_MOSI = 2;

    logic [NPIN-1:0] pin_raw;
    logic [NPIN-1:0] meta_q, meta_d;
    logic [NPIN-1:0] sync_q, sync_d;
    logic [NPIN-1:0] hist_q, hist_d;

    assign pin_raw = {mosi, sck, cs_n};

    always_comb begin
        meta_d = pin_raw;
        sync_d = meta_q;
        hist_d = sync_q;
    end

    generate
        for (genvar gi = 0; gi < NPIN; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_q[gi] <= PIN_RST[gi];
                    sync_q[gi] <= PIN_RST[gi];
                    hist_q[gi] <= PIN_RST[gi];
                end else begin
                    meta_q[gi] <= meta_d[gi];
                    sync_q[gi] <= sync_d[gi];
                    hist_q[gi] <= hist_d[gi];
                end
            end
        end
    endgenerate

    // Edge detection compares the synchronised value with its history copy.
    logic cs_fall;
    logic cs_rise;
    logic sck_rise;
    logic mosi_s;

    assign cs_fall  =  hist_q[PIN_CS]  & ~sync_q[PIN_CS];
    assign cs_rise  = ~hist_q[PIN_CS]  &  sync_q[PIN_CS];
    assign sck_rise = ~hist_q[PIN_SCK] &  sync_q[PIN_SCK];
    assign mosi_s   =  sync_q[PIN_MOSI];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [4:0]  CNT_FULL   = 5'd16;
    localparam logic [4:0]  CNT_SAT    = 5'd17;
    localparam logic [3:0]  ADDR_MARK  = 4'h0;
    localparam logic [3:0]  ADDR_SPACE = 4'h1;
    localparam logic [3:0]  ADDR_BAUD  = 4'h2;
    localparam logic [3:0]  ADDR_CTRL  = 4'h3;
    localparam logic [3:0]  ADDR_SRST  = 4'hF;
    localparam logic [11:0] SRST_KEY   = 12'hA5A;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic [11:0] mark_q, mark_d;
    logic [11:0] space_q, space_d;
    logic [11:0] baud_q, baud_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic        cfg_update_q, cfg_update_d;
    logic        frame_err_q, frame_err_d;

    logic [3:0]  frame_addr;
    logic [11:0] frame_data;

    assign frame_addr = shreg_q[15:12];
    assign frame_data = shreg_q[11:0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        mark_d       = mark_q;
        space_d      = space_q;
        baud_d       = baud_q;
        ctrl_d       = ctrl_q;
        cfg_update_d = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // sck activity while deselected is ignored.
                if (cs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end

            SHIFT: begin
                // cs_rise takes priority over a coincident sck_rise, so the
                // frame is judged on the bits captured before it.
                if (cs_rise) begin
                    state_d = IDLE;
                    if (cnt_q == CNT_FULL) begin
                        cfg_update_d = 1'b1;
                        unique case (frame_addr)
                            ADDR_MARK:  mark_d  = frame_data;
                            ADDR_SPACE: space_d = frame_data;
                            ADDR_BAUD:  baud_d  = frame_data;
                            ADDR_CTRL:  ctrl_d  = frame_data[3:0];
                            ADDR_SRST: begin
                                if (frame_data == SRST_KEY) begin
                                    mark_d  = MARK_RST;
                                    space_d = SPACE_RST;
                                    baud_d  = BAUD_RST;
                                    ctrl_d  = CTRL_RST;
                                end else begin
                                    cfg_update_d = 1'b0;
                                    frame_err_d  = 1'b1;
                                end
                            end
                            default: begin
                                cfg_update_d = 1'b0;
                                frame_err_d  = 1'b1;
                            end
                        endcase
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sck_rise) begin
                    shreg_d = {shreg_q[14:0], mosi_s};
                    // Saturating at 17 keeps over-long frames distinguishable
                    // from exact 16-bit frames without wrapping.
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            mark_q       <= MARK_RST;
            space_q      <= SPACE_RST;
            baud_q       <= BAUD_RST;
            ctrl_q       <= CTRL_RST;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            mark_q       <= mark_d;
            space_q      <= space_d;
            baud_q       <= baud_d;
            ctrl_q       <= ctrl_d;
            cfg_update_q <= cfg_update_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign mark_inc   = mark_q;
    assign space_inc  = space_q;
    assign baud_div   = baud_q;
    assign ctrl       = ctrl_q;
    assign cfg_update = cfg_update_q;
    assign frame_err  = frame_err_q;

endmodule
